reg_bank_gen: RTL
=================

# reg_bank_gen

Parametrised CPU register bank for the tri-mode MAC host interface and the next generation of the per-register CPU write/read-mux block. It provides NREG control registers with packed reset values, self-clearing command registers, sticky hardware status registers and an indirect-read engine with a grant handshake and timeout for RMON-style counter access. It sits between the host bus (CSB/WRB/CA/CD) and the MAC Tx/Rx/RMON/PHY configuration inputs.

## Interface
- DW, 16, register data width
- AW, 8, byte address width; word index = CA[AW-1:1]
- NREG, 36, number of control registers, word indices 0..NREG-1
- INIT, 0, NREG*DW packed reset values; register i = INIT[i*DW +: DW]
- PULSE_MASK, 0, NREG bits; bit i=1 makes register i self-clearing
- NSTAT, 4, number of sticky status registers
- IAW, 6, indirect read address width
- TIMEOUT, 255, grant wait limit in cycles, 1..255
- Clk  in  1  clock
- Reset  in  1  asynchronous, active-high
- CSB  in  1  chip select, active low
- WRB  in  1  0 = write, 1 = read, sampled with CSB
- CA  in  AW  byte address
- CD_in  in  DW  write data
- CD_out  out  DW  registered read data
- Ack  out  1  one-cycle access-complete pulse
- Ctrl_out  out  NREG*DW  control register contents
- Wr_pulse  out  NREG  one-cycle strobe per register write
- Stat_set  in  NSTAT*DW  hardware event bits, level, sampled every cycle
- Ind_rd_addr  out  IAW  indirect read address
- Ind_rd_apply  out  1  indirect read request
- Ind_rd_grant  in  1  indirect read grant; data valid when high
- Ind_rd_dout  in  2*DW  indirect read data

## Operation
- Word map, word index W: 0..NREG-1 control; NREG..NREG+NSTAT-1 status; S=NREG+NSTAT: IND_CMD; S+1: IND_STAT; S+2: IND_DATA_L; S+3: IND_DATA_H; everything else reads 0, writes are ignored.
- Access start: the first Clk edge where CSB=0 and registered csb_q=1. Exactly one access is accepted per CSB-low period.
- Write commit at that edge. Control register i <= CD_in, and Wr_pulse[i]=1 for the next cycle. Writes to IND_STAT and IND_DATA_* are ignored.
- Self-clearing register: holds the written value for exactly one cycle, then reverts to INIT.
- Status register: bit <= bit | Stat_set each cycle. Clearing depends on the configuration macro. When a set and a clear hit the same bit in the same cycle, the set wins.
- IND_CMD write: CD_in[IAW-1:0] is loaded into Ind_rd_addr and the FSM starts. The write is ignored while busy.
- IND_STAT: bit0 busy, bit1 done, bit2 timeout. Done and timeout are cleared by the next IND_CMD write.
- FSM IDLE: apply=0. On an accepted IND_CMD write, go to REQ and clear the counter.
- FSM REQ: apply=1, counter increments.
  - grant=1: shadow <= Ind_rd_dout, set done, go to IDLE, apply drops the next cycle.
  - Counter reaches TIMEOUT with no grant: set timeout, go to IDLE, shadow unchanged.
- When grant and timeout arrive in the same cycle, grant wins.
- IND_DATA_L and IND_DATA_H read shadow[DW-1:0] and shadow[2DW-1:DW].
- Reset values: Ctrl_out=INIT, CD_out=0, Ack=0, Wr_pulse=0, status=0, Ind_rd_apply=0, Ind_rd_addr=0, shadow=0, IND_STAT=0, FSM=IDLE, csb_q=1.
- Reset mid-operation aborts the FSM immediately and drops apply asynchronously.

## Timing
- Read: CD_out loads at the access-start edge and holds until the next access. Ack=1 for the one cycle after that edge.
- Write: the register value is visible on Ctrl_out the cycle after the access-start edge, coincident with Ack and Wr_pulse.
- Minimum CSB high time between accesses: 1 Clk cycle.
- Indirect read: apply rises 1 cycle after the IND_CMD commit. done is readable 1 cycle after the grant edge.
- Status sample latency: 1 cycle from Stat_set to the register.

## Configuration
- REG_BANK_RDCLR_EN defined: a status register clears at its read access-start edge. Writes to status words are ignored.
- REG_BANK_RDCLR_EN undefined: status registers are write-1-to-clear (bit &= ~CD_in). Reads are non-destructive.

## Test plan
- Reset with INIT[0]=16'h001e, INIT[26]=16'h2710 -> Ctrl_out word0=16'h001e, word26=16'h2710; CD_out=0, Ack=0, apply=0.
- Write 16'h1234 to CA=8'h06 (W=3), then read it back -> word3=16'h1234, Wr_pulse[3] high 1 cycle, read CD_out=16'h1234, one Ack per access even with CSB held low 10 cycles.
- PULSE_MASK[10]=1, write 16'h0001 to W=10 -> word10=1 for exactly 1 cycle, then 0.
- Stat_set[0] pulses bit 3 -> status W=NREG reads 16'h0008.
  - With the macro: a second read returns 0.
  - Without the macro: write 16'h0008 clears it; a set coincident with the clear leaves bit 3=1.
- IND_CMD=6'd5, grant after 3 cycles with dout=32'hdeadbeef -> apply high 3 cycles, IND_STAT=3'b010, DATA_L=16'hbeef, DATA_H=16'hdead.
- IND_CMD with grant held 0, TIMEOUT=8 -> apply drops after 8 cycles, IND_STAT=3'b100, shadow unchanged. Assert Reset during REQ -> apply=0 immediately.

Source files
------------

// File: rtl/reg_bank_gen.sv
// CPU register bank: control/self-clearing registers, sticky status and an indirect-read engine.
// Optional macro REG_BANK_RDCLR_EN selects clear-on-read status (default: write-1-to-clear).
module reg_bank_gen #(
  parameter int unsigned         DW         = 16,
  parameter int unsigned         AW         = 8,
  parameter int unsigned         NREG       = 36,
  parameter logic [NREG*DW-1:0]  INIT       = '0,
  parameter logic [NREG-1:0]     PULSE_MASK = '0,
  parameter int unsigned         NSTAT      = 4,
  parameter int unsigned         IAW        = 6,
  parameter int unsigned         TIMEOUT    = 255
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  CSB,
  input  logic                  WRB,
  input  logic [AW-1:0]         CA,
  input  logic [DW-1:0]         CD_in,
  output logic [DW-1:0]         CD_out,
  output logic                  Ack,
  output logic [NREG*DW-1:0]    Ctrl_out,
  output logic [NREG-1:0]       Wr_pulse,
  input  logic [NSTAT*DW-1:0]   Stat_set,
  output logic [IAW-1:0]        Ind_rd_addr,
  output logic                  Ind_rd_apply,
  input  logic                  Ind_rd_grant,
  input  logic [2*DW-1:0]       Ind_rd_dout
);

  localparam int unsigned IndCmd   = NREG + NSTAT;
  localparam int unsigned IndStat  = IndCmd + 1;
  localparam int unsigned IndDataL = IndCmd + 2;
  localparam int unsigned IndDataH = IndCmd + 3;
  localparam logic [7:0]  TimeoutCnt = 8'(TIMEOUT);

  typedef enum logic [0:0] {StIdle, StReq} ind_state_e;

  logic              csb_q;
  logic              acc_start, acc_wr, acc_rd;
  int unsigned       widx;
  logic              unused_ca0;

  logic [DW-1:0]     ctrl_q [NREG];
  logic [DW-1:0]     ctrl_d [NREG];
  logic [NREG-1:0]   wr_pulse_q, wr_pulse_d;
  logic [DW-1:0]     stat_q [NSTAT];
  logic [DW-1:0]     stat_d [NSTAT];
  logic [DW-1:0]     stat_clr [NSTAT];

  ind_state_e        state_q, state_d;
  logic [7:0]        cnt_q, cnt_d, cnt_inc;
  logic [IAW-1:0]    addr_q, addr_d;
  logic [2*DW-1:0]   shadow_q, shadow_d;
  logic              done_q, done_d, tout_q, tout_d;
  logic              busy;

  logic [DW-1:0]     rdata;
  logic [DW-1:0]     cd_out_q;
  logic              ack_q;

  // One access per CSB-low period: start only on the falling CSB edge as seen by csb_q.
  assign acc_start  = !CSB && csb_q;
  assign acc_wr     = acc_start && !WRB;
  assign acc_rd     = acc_start && WRB;
  assign widx       = 32'(CA[AW-1:1]);
  assign unused_ca0 = CA[0];
  assign busy       = (state_q == StReq);
  assign cnt_inc    = cnt_q + 8'd1;

  always_comb begin
    for (int unsigned i = 0; i < NREG; i++) begin
      ctrl_d[i]     = ctrl_q[i];
      wr_pulse_d[i] = acc_wr && (widx == i);
      // Self-clearing registers fall back to their reset value after one visible cycle.
      if (PULSE_MASK[i] && wr_pulse_q[i]) ctrl_d[i] = INIT[i*DW +: DW];
      if (acc_wr && (widx == i))          ctrl_d[i] = CD_in;
    end
  end

  always_comb begin
    for (int unsigned j = 0; j < NSTAT; j++) begin
      stat_clr[j] = '0;
`ifdef REG_BANK_RDCLR_EN
      if (acc_rd && (widx == NREG + j)) stat_clr[j] = '1;
`else
      if (acc_wr && (widx == NREG + j)) stat_clr[j] = CD_in;
`endif
      // Set is applied after clear so a coincident event is never lost.
      stat_d[j] = (stat_q[j] & ~stat_clr[j]) | Stat_set[j*DW +: DW];
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    shadow_d = shadow_q;
    done_d   = done_q;
    tout_d   = tout_q;
    unique case (state_q)
      StIdle: begin
        if (acc_wr && (widx == IndCmd)) begin
          addr_d  = CD_in[IAW-1:0];
          done_d  = 1'b0;
          tout_d  = 1'b0;
          cnt_d   = '0;
          state_d = StReq;
        end
      end
      StReq: begin
        cnt_d = cnt_inc;
        if (Ind_rd_grant) begin
          shadow_d = Ind_rd_dout;
          done_d   = 1'b1;
          state_d  = StIdle;
        end else if (cnt_inc == TimeoutCnt) begin
          tout_d  = 1'b1;
          state_d = StIdle;
        end
      end
    endcase
  end

  always_comb begin
    rdata = '0;
    for (int unsigned i = 0; i < NREG; i++) begin
      if (widx == i) rdata = ctrl_q[i];
    end
    for (int unsigned j = 0; j < NSTAT; j++) begin
      if (widx == NREG + j) rdata = stat_q[j];
    end
    if (widx == IndCmd)   rdata = DW'(addr_q);
    if (widx == IndStat)  rdata = DW'({tout_q, done_q, busy});
    if (widx == IndDataL) rdata = shadow_q[DW-1:0];
    if (widx == IndDataH) rdata = shadow_q[2*DW-1:DW];
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      csb_q      <= 1'b1;
      cd_out_q   <= '0;
      ack_q      <= 1'b0;
      wr_pulse_q <= '0;
      for (int unsigned i = 0; i < NREG; i++) ctrl_q[i] <= INIT[i*DW +: DW];
      for (int unsigned j = 0; j < NSTAT; j++) stat_q[j] <= '0;
      state_q    <= StIdle;
      cnt_q      <= '0;
      addr_q     <= '0;
      shadow_q   <= '0;
      done_q     <= 1'b0;
      tout_q     <= 1'b0;
    end else begin
      csb_q      <= CSB;
      ack_q      <= acc_start;
      wr_pulse_q <= wr_pulse_d;
      if (acc_rd) cd_out_q <= rdata;
      for (int unsigned i = 0; i < NREG; i++) ctrl_q[i] <= ctrl_d[i];
      for (int unsigned j = 0; j < NSTAT; j++) stat_q[j] <= stat_d[j];
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      shadow_q   <= shadow_d;
      done_q     <= done_d;
      tout_q     <= tout_d;
    end
  end

  for (genvar g = 0; g < NREG; g++) begin : g_ctrl_out
    assign Ctrl_out[g*DW +: DW] = ctrl_q[g];
  end

  assign CD_out       = cd_out_q;
  assign Ack          = ack_q;
  assign Wr_pulse     = wr_pulse_q;
  assign Ind_rd_addr  = addr_q;
  assign Ind_rd_apply = busy;

endmodule
